// File: rtl/fpu_pkg.sv
// Shared FPU definitions: reciprocal unit latency, fp32 type and the tag
// that travels alongside each finv operation.
package fpu_pkg;

  // Pipeline depth of the finv reciprocal unit in clocks.
  localparam int FINV_LAT = 3;

  // Tag id width covers the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } finv_tag_t;

endpackage

// File: rtl/finv.sv
// finv: pipelined IEEE-754 single reciprocal, fixed FINV_LAT latency, no
// stall. Mantissa quotient is truncated. Denormal inputs are treated as zero
// (result signed infinity); results that would be denormal flush to signed
// zero; infinity gives signed zero; NaN gives the canonical quiet NaN.
// The data pipeline is deliberately not reset.
module finv
  import fpu_pkg::*;
(
  input  logic  clk,
  input  fp32_t x,
  output fp32_t y
);

  logic              sgn;
  logic [7:0]        ex;
  logic [22:0]       man;
  logic [25:0]       quo;
  logic signed [9:0] ex_res;
  fp32_t             recip;
  fp32_t             pipe [FINV_LAT];
  logic              unused_quo_bits;

  assign sgn = x[31];
  assign ex  = x[30:23];
  assign man = x[22:0];

  // 2^48 / 1.m scaled: for m != 0 the result lies in (2^24, 2^25).
  assign quo = 26'(49'h1_0000_0000_0000 / {25'd0, 1'b1, man});
  assign unused_quo_bits = ^{quo[25:24], quo[0]};

  // Combinational reciprocal with special-case handling.
  always_comb begin
    ex_res = (man == '0) ? (10'sd254 - $signed({2'b00, ex}))
                         : (10'sd253 - $signed({2'b00, ex}));
    recip  = '0;
    if (ex == 8'hFF) begin
      recip = (man != '0) ? 32'h7FC0_0000 : {sgn, 31'd0};
    end else if (ex == 8'h00) begin
      recip = {sgn, 8'hFF, 23'd0};
    end else if (ex_res <= 10'sd0) begin
      recip = {sgn, 31'd0};
    end else if (man == '0) begin
      recip = {sgn, ex_res[7:0], 23'd0};
    end else begin
      recip = {sgn, ex_res[7:0], quo[23:1]};
    end
  end

  // Fixed-latency data pipeline; validity is tracked by the caller.
  always_ff @(posedge clk) begin
    pipe[0] <= recip;
    for (int k = 1; k < FINV_LAT; k++) begin
      pipe[k] <= pipe[k-1];
    end
  end

  assign y = pipe[FINV_LAT-1];

endmodule

// File: rtl/finv_arb.sv
// finv_arb: round-robin arbiter sharing one finv unit among NREQ requesters.
// A tag pipeline matched to the finv latency routes each result back to its
// originator; per-requester outstanding counters bound in-flight work.
// Optional build macro FINV_ARB_STATS_EN adds stat_issue / stat_stall counters.
//
// Handshake: a transfer happens in a cycle where req_valid[i] && req_ready[i];
// req_ready is at most one-hot, low during reset, and depends only on
// req_valid and registered arbiter state (never on req_x). Responses carry no
// ready: rsp_valid[i] must be accepted in the cycle it is shown.
module finv_arb
  import fpu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LAT     = FINV_LAT,  // must match the finv instance latency
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0][31:0] req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output fp32_t                rsp_y,
  output logic                 busy
`ifdef FINV_ARB_STATS_EN
  ,
  output logic [31:0]          stat_issue,
  output logic [31:0]          stat_stall
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [IW-1:0]   ptr;
  logic [CW-1:0]   outst [NREQ];
  finv_tag_t       tags  [LAT];
  logic [NREQ-1:0] ret;
  logic [NREQ-1:0] elig;
  logic            grant_any;
  logic [IW-1:0]   grant_id;
  int              idx;
  fp32_t           finv_x;
  fp32_t           finv_y;

  // Requester whose result leaves the tag pipeline this cycle.
  always_comb begin
    ret = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (tags[LAT-1].valid && (int'(tags[LAT-1].id) == i)) ret[i] = 1'b1;
    end
  end

  // Eligibility: a slot being returned this cycle counts as already free, so
  // MAX_OUT == LAT sustains one issue per cycle from a single requester.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && ((outst[i] < CW'(MAX_OUT)) || ret[i]);
    end
  end

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    req_ready = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!grant_any && elig[idx]) begin
          grant_any = 1'b1;
          grant_id  = IW'(idx);
        end
      end
      if (grant_any) req_ready[grant_id] = 1'b1;
    end
  end

  assign finv_x = grant_any ? req_x[grant_id] : '0;

  finv u_finv (
    .clk (clk),
    .x   (finv_x),
    .y   (finv_y)
  );

  // Tag shift pipeline, one stage per finv clock, never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) tags[k] <= '0;
    end else begin
      tags[0].valid <= grant_any;
      tags[0].id    <= TAG_ID_W'(grant_id);
      for (int k = 1; k < LAT; k++) tags[k] <= tags[k-1];
    end
  end

  // Round-robin pointer moves past the granted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Outstanding counters: +1 on issue, -1 on return, unchanged when both.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst) begin
        outst[i] <= '0;
      end else if (grant_any && (int'(grant_id) == i) && !ret[i]) begin
        outst[i] <= outst[i] + 1'b1;
      end else if (!(grant_any && (int'(grant_id) == i)) && ret[i]) begin
        outst[i] <= outst[i] - 1'b1;
      end
    end
  end

  assign rsp_valid = ret;
  assign rsp_y     = finv_y;

  // Busy while any tag stage holds a live operation.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LAT; k++) busy = busy | tags[k].valid;
  end

`ifdef FINV_ARB_STATS_EN
  logic any_cap_stall;

  // A stall cycle: some requester wants to issue but has no free slot.
  always_comb begin
    any_cap_stall = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !((outst[i] < CW'(MAX_OUT)) || ret[i])) any_cap_stall = 1'b1;
    end
  end

  // Free-running wrap-around activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      if (grant_any)     stat_issue <= stat_issue + 32'd1;
      if (any_cap_stall) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_finv_arb.sv
// Bench for finv_arb: directed scenarios followed by a random phase, all
// checked against an in-order model of outstanding operations.
module tb_finv_arb;
  import fpu_pkg::*;

  localparam int NREQ    = 4;
  localparam int LAT     = 3;
  localparam int MAX_OUT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][31:0] req_x;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [31:0]           rsp_y;
  logic                  busy;
`ifdef FINV_ARB_STATS_EN
  logic [31:0]           stat_issue;
  logic [31:0]           stat_stall;
`endif

  finv_arb #(.NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .busy      (busy)
`ifdef FINV_ARB_STATS_EN
    ,
    .stat_issue(stat_issue),
    .stat_stall(stat_stall)
`endif
  );

  // ---------------- scoreboard / model ----------------
  // Results return in issue order (fixed latency), so plain FIFOs suffice.
  logic [31:0] exp_q[$];
  int          exp_id_q[$];
  int          exp_due_q[$];
  int          m_ptr;
  int          cyc;
  int          m_issue;
  int          m_stall;
  int          g_now;
  bit          stall_now;
  int          n_assert;
  int          n_fail;

  function automatic logic [31:0] recip_model(input logic [31:0] x);
    // x = +-2^(e-127)  ->  1/x = +-2^(127-e), biased exponent 254-e.
    int e;
    e = int'(x[30:23]);
    return {x[31], 8'(254 - e), 23'd0};
  endfunction

  function automatic logic [31:0] rand_pow2();
    logic [7:0] e;
    e = 8'($urandom_range(2, 253));
    return {1'($urandom_range(0, 1)), e, 23'd0};
  endfunction

  // Operations of requester id still occupying a slot (not returning now).
  function automatic int pending(input int id);
    int n;
    n = 0;
    for (int j = 0; j < exp_id_q.size(); j++) begin
      if (exp_id_q[j] == id && exp_due_q[j] > cyc) n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Sample outputs mid-cycle and compare against the model.
  task automatic check_cycle();
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_rsp;
    int idx;
    @(negedge clk);
    exp_ready = '0;
    g_now     = -1;
    stall_now = 1'b0;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g_now < 0 && req_valid[idx] && pending(idx) < MAX_OUT) g_now = idx;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && pending(i) >= MAX_OUT) stall_now = 1'b1;
      end
    end
    if (g_now >= 0) exp_ready[g_now] = 1'b1;
    exp_rsp = '0;
    if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) exp_rsp[exp_id_q[0]] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp != '0) chk("rsp_y", rsp_y, exp_q[0]);
    chk("busy", 32'(busy), 32'(exp_q.size() > 0));
`ifdef FINV_ARB_STATS_EN
    chk("stat_issue", stat_issue, 32'(m_issue));
    chk("stat_stall", stat_stall, 32'(m_stall));
`endif
  endtask

  // Clock edge: update the model, then release inputs for the next cycle.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_id_q.delete();
      exp_due_q.delete();
      m_ptr   = 0;
      m_issue = 0;
      m_stall = 0;
    end else begin
      if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
        void'(exp_q.pop_front());
        void'(exp_id_q.pop_front());
        void'(exp_due_q.pop_front());
      end
      if (g_now >= 0) begin
        exp_q.push_back(recip_model(req_x[g_now]));
        exp_id_q.push_back(g_now);
        exp_due_q.push_back(cyc + LAT);
        m_ptr = (g_now + 1) % NREQ;
        m_issue++;
      end
      if (stall_now) m_stall++;
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    check_cycle();
    advance();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [5:0] s3_pat;
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    m_ptr    = 0;
    m_issue  = 0;
    m_stall  = 0;
    g_now    = -1;
    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    @(posedge clk);
    #1;

    // Reset state, and no grant while reset is held even with requests.
    step();
    req_valid = 4'b1111;
    check_cycle();
    chk("rst_no_grant", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    advance();
    req_valid = '0;
    rst = 1'b0;
    step();
    step();

    // Single requester 0, x = 2.0 -> 0.5 three cycles later.
    req_valid = 4'b0001;
    req_x[0]  = 32'h4000_0000;
    check_cycle();
    chk("s1_ready", 32'(req_ready), 32'h1);
    advance();
    req_valid = '0;
    step();
    step();
    check_cycle();
    chk("s1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("s1_rsp_y", rsp_y, 32'h3F00_0000);
    advance();

    // All four valid with 1.0 from reset: grants rotate 0,1,2,3,...
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_x[i] = 32'h3F80_0000;
    for (int k = 0; k < 8; k++) begin
      check_cycle();
      chk("s2_grant", 32'(req_ready), 32'(1 << (k % NREQ)));
      if (k >= LAT) begin
        chk("s2_rsp_id", 32'(rsp_valid), 32'(1 << ((k - LAT) % NREQ)));
        chk("s2_rsp_y", rsp_y, 32'h3F80_0000);
      end
      advance();
    end
    req_valid = '0;
    for (int k = 0; k < LAT + 1; k++) step();

    // Requester 2 alone: MAX_OUT=2 gives issue, issue, stall, repeating.
    do_reset();
    s3_pat    = 6'b011011;
    req_valid = 4'b0100;
    req_x[2]  = rand_pow2();
    for (int k = 0; k < 6; k++) begin
      check_cycle();
      chk("s3_ready", 32'(req_ready), s3_pat[k] ? 32'h4 : 32'h0);
      advance();
      req_x[2] = rand_pow2();
    end
    req_valid = '0;
`ifdef FINV_ARB_STATS_EN
    check_cycle();
    chk("s3_stat_issue", stat_issue, 32'd4);
    chk("s3_stat_stall", stat_stall, 32'd2);
    advance();
`endif
    for (int k = 0; k < LAT + 1; k++) step();

    // Reset right after an issue discards the in-flight result.
    req_valid = 4'b0010;
    req_x[1]  = 32'hC080_0000;
    step();
    rst       = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_cycle();
      chk("s4_no_rsp", 32'(rsp_valid), 32'd0);
      chk("s4_busy", 32'(busy), 32'd0);
      advance();
    end
    req_valid = 4'b1111;
    check_cycle();
    chk("s4_ptr0_grant", 32'(req_ready), 32'h1);
    advance();
    req_valid = '0;
    for (int k = 0; k < LAT + 1; k++) step();

    // ptr = 3 with requesters 1 and 2 valid: wrap to 1, then 2.
    do_reset();
    req_valid = 4'b0100;
    req_x[2]  = rand_pow2();
    step();
    req_valid = 4'b0110;
    req_x[1]  = rand_pow2();
    check_cycle();
    chk("s5_wrap_grant1", 32'(req_ready), 32'h2);
    advance();
    check_cycle();
    chk("s5_then_grant2", 32'(req_ready), 32'h4);
    advance();
    req_valid = '0;
    for (int k = 0; k < LAT + 1; k++) step();

    // Random traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) req_x[i] = rand_pow2();
      step();
    end
    rst       = 1'b0;
    req_valid = '0;
    for (int k = 0; k < LAT + 2; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/finv_arb.md
# finv_arb

Round-robin arbiter and sequencer that shares one pipelined reciprocal unit (`finv`, fixed 3-cycle latency, no stall) among `NREQ` requesters in the FPU. Each cycle it grants at most one requester, issues that requester's operand into `finv`, and carries a requester tag through a valid/tag shift pipeline matched to the unit's latency. It returns each result to its originator on a shared data bus with a one-hot valid. Per-requester outstanding counters stop any one requester from overrunning its return buffer.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `LAT`, default 3: `finv` latency in clocks; must equal the instantiated unit's latency.
- `MAX_OUT`, default 2: maximum in-flight operations per requester, 1..`LAT`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `req_valid` in `NREQ`: per-requester operand valid.
- `req_x` in `NREQ`×32: per-requester IEEE-754 single operand.
- `req_ready` out `NREQ`: one-hot or zero; combinational grant.
- `rsp_valid` out `NREQ`: one-hot or zero; result valid for that requester.
- `rsp_y` out 32: result data, shared by all requesters.
- `busy` out 1: high while any operation is in flight.

## Operation
- A requester is eligible when `req_valid[i]` is high and `outst[i] < MAX_OUT`.
- Round-robin grant: search starts at `ptr` and wraps modulo `NREQ`. The first eligible requester gets `req_ready[i]`=1.
- A transfer occurs when `req_valid[i] && req_ready[i]`. `req_ready` never depends on anything except `req_valid`, `ptr`, `outst`.
- On a transfer, `ptr` moves to i+1 (wraps to 0). With no transfer, `ptr` holds.
- The granted `req_x` is muxed combinationally onto the `finv` input. With no grant, the mux drives 0 and the tag valid is 0.
- Tag pipeline: `LAT` stages of {valid, id[$clog2(NREQ)-1:0]}, shifted every cycle with no stall.
- At the last stage, `rsp_valid[id]` = valid and `rsp_y` = `finv` output.
- Requesters must accept responses unconditionally; there is no response backpressure.
- `outst[i]` is a width-$clog2(MAX_OUT+1) counter: +1 on issue, −1 on response.
  - If issue and response for the same i fall in the same cycle, the counter is unchanged.
  - No overflow or underflow by construction.
- `busy` = OR of all tag valids.
- `rsp_y` is don't-care when `rsp_valid` is 0.

## Timing
- Issue in cycle t produces `rsp_valid` in cycle t+`LAT`, i.e. t+3 by default.
- Full throughput is one issue per cycle across all requesters.
- A single requester with `MAX_OUT`=2 and `LAT`=3 is limited to 2 issues per 3 cycles.
- `MAX_OUT`=`LAT` gives full single-requester throughput.
- Reset values, in the cycle after a `rst` edge:
  - all tag valids 0, `ptr`=0, all `outst`=0;
  - `rsp_valid`=0, `busy`=0;
  - `req_ready` is then a function of inputs only.
- While `rst` is high: no grant (`req_ready`=0). `finv` data is not reset; the tag valids gate it.
- Reset mid-operation: in-flight results are discarded, with no response emitted, and requesters must drop their expectations.
- If the only eligible requester sits at `ptr`, it is granted. If none is eligible, there is no grant.

## Configuration
- `FINV_ARB_STATS_EN` defined:
  - adds output `stat_issue` (32) and output `stat_stall` (32), both reset to 0 and wrapping modulo 2^32;
  - `stat_issue` +1 per transfer;
  - `stat_stall` +1 per cycle in which some `req_valid[i]` is high but that requester is ineligible because `outst[i]==MAX_OUT`.
- Not defined: those ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `fpu_pkg`:
  - `FINV_LAT`=3 constant, used as the `LAT` default;
  - `fp32_t` typedef (32-bit);
  - tag struct typedef {valid, id}.
- One sub-module: `finv` (existing, instantiated once, latency `FINV_LAT`).
- Round-robin grant logic stays inline.

## Test plan
- Single requester 0, x=0x40000000 (2.0) in cycle 5 -> `req_ready[0]`=1 in cycle 5; `rsp_valid`=0001 and `rsp_y`=0x3F000000 in cycle 8.
- All 4 requesters held valid with x=0x3F800000 (1.0) from reset -> grants in order 0,1,2,3,0,… one per cycle; each response is 0x3F800000 with ids in the same order, 3 cycles later.
- Requester 2 alone, valid continuously, `MAX_OUT`=2 -> issues at t, t+1; stalls at t+2; issues again at t+3, the same cycle as the first response. `outst[2]` holds at 2.
- Requester 1 issues x=0xC0800000 (−4.0) in cycle 10 and `rst` is high in cycle 11 -> no `rsp_valid` in cycles 12–14; `busy`=0 and `ptr`=0 after reset.
- `ptr`=3, requesters 1 and 2 valid -> grant 1 (wraps past 3,0), then `ptr`=2 -> grant 2.
- With `FINV_ARB_STATS_EN`: after the third scenario for 6 cycles -> `stat_issue`=4, `stat_stall`=2.
